// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller: state encoding, the
// hard-wired zero register and the source/destination match helper.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun    = 2'b00,
      StDrain  = 2'b01,
      StHalted = 2'b10
   } hz_state_e;

   localparam logic [3:0] REG_ZERO = 4'h0;

   // Writes to the zero register are discarded, so they can never feed a dependent read.
   function automatic logic reg_match(logic [3:0] src, logic uses, logic [3:0] dst);
      return uses && (src == dst) && (dst != REG_ZERO);
   endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter used for hazard-controller performance statistics.
// Holds at all-ones instead of wrapping; synchronous active-high clear.
module hz_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller: load-use and flag-before-branch stalls, taken-branch
// squash, and HLT drain sequencing. Control outputs are combinational for same-cycle use.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_RS,
   input  logic [3:0]       id_RT,
   input  logic             id_uses_RS,
   input  logic             id_uses_RT,
   input  logic             id_br_cond,
   input  logic             id_HLT,
   input  logic             br_taken,
   input  logic             ex_MemRead,
   input  logic [3:0]       ex_RD,
   input  logic             ex_flag_wr,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned DrainW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

   hz_state_e         state_q, state_d;
   logic [DrainW-1:0] drain_q, drain_d;
   logic              lu, fh, hz;
   logic              stall_inc, flush_inc;

   assign lu = ex_MemRead && (reg_match(id_RS, id_uses_RS, ex_RD) ||
                              reg_match(id_RT, id_uses_RT, ex_RD));
   assign fh = id_br_cond & ex_flag_wr;
   assign hz = lu | fh;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      halted      = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      case (state_q)
         StRun: begin
            if (hz) begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               id_ex_flush = 1'b1;
               stall_inc   = 1'b1;
            end else if (id_HLT) begin
               // HLT moves on to EX; fetch is frozen and wrong-path fetch squashed.
               pc_stall    = 1'b1;
               if_id_flush = 1'b1;
               drain_d     = DrainW'(DRAIN_CYCLES);
               state_d     = StDrain;
            end else if (br_taken) begin
               if_id_flush = 1'b1;
               flush_inc   = 1'b1;
            end
         end
         StDrain: begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            drain_d     = drain_q - DrainW'(1);
            if (drain_q <= DrainW'(1)) begin
               state_d = StHalted;
            end
         end
         StHalted: begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            halted      = 1'b1;
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   hz_sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk(clk),
      .rst(rst),
      .inc(stall_inc),
      .q  (stall_cnt)
   );

   hz_sat_counter #(
      .CNT_W(CNT_W)
   ) u_flush_cnt (
      .clk(clk),
      .rst(rst),
      .inc(flush_inc),
      .q  (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized stimulus checked
// against a behavioural model of the stall/flush/halt rules.
module tb_hazard_ctrl;

   localparam int unsigned DrainCycles = 3;
   localparam int unsigned CntW        = 8;
   localparam int          CntMax      = (1 << CntW) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      id_RS, id_RT, ex_RD;
   logic            id_uses_RS, id_uses_RT, id_br_cond, id_HLT, br_taken;
   logic            ex_MemRead, ex_flag_wr;
   logic            pc_stall, if_id_stall, if_id_flush, id_ex_flush, halted;
   logic [CntW-1:0] stall_cnt, flush_cnt;

   // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, halted}
   logic [4:0] dut_o;
   assign dut_o = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, halted};

   hazard_ctrl #(
      .DRAIN_CYCLES(DrainCycles),
      .CNT_W       (CntW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .id_RS      (id_RS),
      .id_RT      (id_RT),
      .id_uses_RS (id_uses_RS),
      .id_uses_RT (id_uses_RT),
      .id_br_cond (id_br_cond),
      .id_HLT     (id_HLT),
      .br_taken   (br_taken),
      .ex_MemRead (ex_MemRead),
      .ex_RD      (ex_RD),
      .ex_flag_wr (ex_flag_wr),
      .pc_stall   (pc_stall),
      .if_id_stall(if_id_stall),
      .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush),
      .halted     (halted),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: mode 0 = running, 1 = draining, 2 = halted.
   int m_mode = 0;
   int m_left = 0;
   int m_stall = 0;
   int m_flush = 0;

   function automatic logic model_hz();
      logic lu, fh;
      lu = ex_MemRead && (ex_RD != 4'd0) &&
           ((id_uses_RS && id_RS == ex_RD) || (id_uses_RT && id_RT == ex_RD));
      fh = id_br_cond && ex_flag_wr;
      return lu || fh;
   endfunction

   function automatic logic [4:0] model_outs();
      if (m_mode == 2) return 5'b11011;
      if (m_mode == 1) return 5'b10100;
      if (model_hz()) return 5'b11010;
      if (id_HLT) return 5'b10100;
      if (br_taken) return 5'b00100;
      return 5'b00000;
   endfunction

   // Advance the model using the inputs present this cycle, then cross one clock edge.
   task automatic tick();
      logic h;
      h = model_hz();
      if (rst) begin
         m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
      end else if (m_mode == 0) begin
         if (h) m_stall = (m_stall < CntMax) ? m_stall + 1 : m_stall;
         else if (id_HLT) begin m_mode = 1; m_left = DrainCycles; end
         else if (br_taken) m_flush = (m_flush < CntMax) ? m_flush + 1 : m_flush;
      end else if (m_mode == 1) begin
         if (m_left <= 1) m_mode = 2;
         else m_left = m_left - 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_RS = '0; id_RT = '0; ex_RD = '0;
      id_uses_RS = 0; id_uses_RT = 0; id_br_cond = 0; id_HLT = 0; br_taken = 0;
      ex_MemRead = 0; ex_flag_wr = 0;
   endtask

   task automatic rand_inputs(int hlt_pct);
      id_RS      = 4'($urandom_range(0, 3));
      id_RT      = 4'($urandom_range(0, 3));
      ex_RD      = 4'($urandom_range(0, 3));
      id_uses_RS = 1'($urandom_range(0, 1));
      id_uses_RT = 1'($urandom_range(0, 1));
      id_br_cond = 1'($urandom_range(0, 1));
      ex_MemRead = 1'($urandom_range(0, 1));
      ex_flag_wr = 1'($urandom_range(0, 3) == 0);
      br_taken   = 1'($urandom_range(0, 1));
      id_HLT     = 1'(int'($urandom_range(0, 99)) < hlt_pct);
   endtask

   task automatic do_reset();
      rst = 1;
      clear_inputs();
      tick();
      rst = 0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (dut_o !== 5'b00000) $display("FAIL reset_outs got=%b want=%b", dut_o, 5'b00000);
      else n_pass++;
      n_checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0)
         $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
      else n_pass++;
   endtask

   task automatic test_load_use();
      do_reset();
      ex_MemRead = 1; ex_RD = 4'd5; id_RS = 4'd5; id_uses_RS = 1;
      #1;
      n_checks++;
      if (dut_o !== 5'b11010) $display("FAIL lu_stall got=%b want=%b", dut_o, 5'b11010);
      else n_pass++;
      tick();
      clear_inputs();
      #1;
      n_checks++;
      if (dut_o !== 5'b00000 || stall_cnt !== CntW'(1))
         $display("FAIL lu_one_cycle got=%b cnt=%0d want=00000 cnt=1", dut_o, stall_cnt);
      else n_pass++;
      // Reg 0 destination and unused source must not stall.
      ex_MemRead = 1; ex_RD = 4'd0; id_RS = 4'd0; id_uses_RS = 1;
      #1;
      n_checks++;
      if (dut_o !== 5'b00000) $display("FAIL lu_reg0 got=%b want=00000", dut_o);
      else n_pass++;
      tick();
      ex_RD = 4'd5; id_RS = 4'd5; id_uses_RS = 0;
      #1;
      n_checks++;
      if (dut_o !== 5'b00000) $display("FAIL lu_unused got=%b want=00000", dut_o);
      else n_pass++;
      tick();
      id_uses_RT = 1; id_RT = 4'd5;
      #1;
      n_checks++;
      if (dut_o !== 5'b11010) $display("FAIL lu_rt got=%b want=11010", dut_o);
      else n_pass++;
      tick();
      n_checks++;
      if (stall_cnt !== CntW'(2)) $display("FAIL lu_cnt got=%0d want=2", stall_cnt);
      else n_pass++;
   endtask

   task automatic test_branch();
      do_reset();
      br_taken = 1;
      #1;
      n_checks++;
      if (dut_o !== 5'b00100) $display("FAIL br_flush got=%b want=00100", dut_o);
      else n_pass++;
      tick();
      n_checks++;
      if (flush_cnt !== CntW'(1)) $display("FAIL br_cnt got=%0d want=1", flush_cnt);
      else n_pass++;
      do_reset();
      br_taken = 1; ex_MemRead = 1; ex_RD = 4'd3; id_RT = 4'd3; id_uses_RT = 1;
      #1;
      n_checks++;
      if (dut_o !== 5'b11010) $display("FAIL br_lu got=%b want=11010", dut_o);
      else n_pass++;
      tick();
      n_checks++;
      if (flush_cnt !== '0 || stall_cnt !== CntW'(1))
         $display("FAIL br_lu_cnt got=%0d/%0d want=1/0", stall_cnt, flush_cnt);
      else n_pass++;
   endtask

   task automatic test_flag_branch();
      do_reset();
      id_br_cond = 1; ex_flag_wr = 1; br_taken = 1;
      #1;
      n_checks++;
      if (dut_o !== 5'b11010) $display("FAIL fh_stall got=%b want=11010", dut_o);
      else n_pass++;
      tick();
      ex_flag_wr = 0;
      #1;
      n_checks++;
      if (dut_o !== 5'b00100) $display("FAIL fh_then_br got=%b want=00100", dut_o);
      else n_pass++;
      tick();
      n_checks++;
      if (stall_cnt !== CntW'(1) || flush_cnt !== CntW'(1))
         $display("FAIL fh_cnt got=%0d/%0d want=1/1", stall_cnt, flush_cnt);
      else n_pass++;
   endtask

   task automatic test_halt();
      logic [CntW-1:0] s0, f0;
      do_reset();
      rand_inputs(0);
      ex_MemRead = 0; ex_flag_wr = 0; id_HLT = 1; br_taken = 1;
      s0 = CntW'(m_stall); f0 = CntW'(m_flush);
      #1;
      n_checks++;
      if (dut_o !== 5'b10100) $display("FAIL hlt_enter got=%b want=10100", dut_o);
      else n_pass++;
      tick();
      for (int i = 0; i < int'(DrainCycles); i++) begin
         rand_inputs(50);
         #1;
         n_checks++;
         if (dut_o !== 5'b10100) $display("FAIL hlt_drain%0d got=%b want=10100", i, dut_o);
         else n_pass++;
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         rand_inputs(50);
         #1;
         n_checks++;
         if (dut_o !== 5'b11011) $display("FAIL hlt_held%0d got=%b want=11011", i, dut_o);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (stall_cnt !== s0 || flush_cnt !== f0)
         $display("FAIL hlt_frozen got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, s0, f0);
      else n_pass++;
   endtask

   task automatic test_rst_mid();
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         br_taken = 1;
         tick();
         clear_inputs();
         id_HLT = 1;
         tick();
         clear_inputs();
         for (int i = 0; i < ((pass == 0) ? 1 : int'(DrainCycles) + 2); i++) tick();
         n_checks++;
         if (dut_o !== model_outs())
            $display("FAIL rst_pre%0d got=%b want=%b", pass, dut_o, model_outs());
         else n_pass++;
         do_reset();
         n_checks++;
         if (dut_o !== 5'b00000 || stall_cnt !== '0 || flush_cnt !== '0)
            $display("FAIL rst_mid%0d got=%b cnt=%0d/%0d want=00000 cnt=0/0", pass, dut_o,
                     stall_cnt, flush_cnt);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      do_reset();
      ex_MemRead = 1; ex_RD = 4'd9; id_RS = 4'd9; id_uses_RS = 1;
      for (int i = 0; i < CntMax + 6; i++) tick();
      n_checks++;
      if (stall_cnt !== {CntW{1'b1}})
         $display("FAIL sat_stall got=%0d want=%0d", stall_cnt, CntMax);
      else n_pass++;
      n_checks++;
      if (dut_o !== 5'b11010) $display("FAIL sat_outs got=%b want=11010", dut_o);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rand_inputs(2);
         rst = (m_mode == 2) && ($urandom_range(0, 7) == 0);
         #1;
         if (!rst) begin
            n_checks++;
            if (dut_o !== model_outs())
               $display("FAIL rand_outs cyc=%0d got=%b want=%b", i, dut_o, model_outs());
            else n_pass++;
         end
         tick();
         n_checks++;
         if (stall_cnt !== CntW'(m_stall) || flush_cnt !== CntW'(m_flush))
            $display("FAIL rand_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, stall_cnt,
                     flush_cnt, m_stall, m_flush);
         else n_pass++;
      end
      rst = 0;
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_branch();
      test_flag_branch();
      test_halt();
      test_rst_mid();
      test_saturation();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
